data_mem_access_unit: RTL and testbench

//  Executes the load/store requested by the main decoder's MemRead/MemWrite in the MEM stage.

---
 rtl/data_mem_access_unit_pkg.sv | 40 ++++
 rtl/data_mem_access_unit_load_extend.sv | 29 ++
 rtl/data_mem_access_unit.sv | 183 ++++++++++++++++++
 tb/tb_data_mem_access_unit.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_access_unit_pkg.sv
// Shared funct3 codes, FSM states and address helpers for the MEM-stage data access unit.
// Misalignment handling is selected by the MISALIGN_TRAP_EN macro in the top.
package data_mem_access_unit_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        DMA_IDLE = 2'd0,
        DMA_BUS  = 2'd1,
        DMA_RESP = 2'd2
    } dma_state_e;

    function automatic logic f3_legal(input logic is_rd, input logic [2:0] f3);
        if (is_rd) begin
            return f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
        end
        return f3 inside {F3_SB, F3_SH, F3_SW};
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
        return ((f3[1:0] == 2'b01) && off[0]) || ((f3[1:0] == 2'b10) && (off != 2'b00));
    endfunction

    // Drops the low offset bits a half/word access cannot use.
    function automatic logic [1:0] align_off(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b01:   return {off[1], 1'b0};
            2'b10:   return 2'b00;
            default: return off;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_access_unit_load_extend.sv
// Load data lane select and sign/zero extension.
// Purely combinational: bus word, byte offset and funct3 in, register value out.
import data_mem_access_unit_pkg::*;

module data_mem_access_unit_load_extend (
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [31:0] shifted;
    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        shifted = word >> {off, 3'b000};
        b       = shifted[7:0];
        h       = off[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_LB:   result = {{24{b[7]}}, b};
            F3_LBU:  result = {24'h0, b};
            F3_LH:   result = {{16{h[15]}}, h};
            F3_LHU:  result = {16'h0, h};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/data_mem_access_unit.sv
// MEM-stage load/store unit: req/ack data bus master with byte enables and load extension.
// Define MISALIGN_TRAP_EN to report misaligned half/word accesses as errors instead of aligning them.
import data_mem_access_unit_pkg::*;

module data_mem_access_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    dma_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic        err_q, err_d;
    logic        is_rd_q, is_rd_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] rdata_q, rdata_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [3:0]  bus_be_q, bus_be_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;

    logic        accept;
    logic        bad;
    logic [1:0]  off_in;
    logic [3:0]  be_in;
    logic [31:0] wd_in;
    logic [31:0] ext;

`ifdef MISALIGN_TRAP_EN
    assign off_in = addr[1:0];
    assign bad    = !f3_legal(mem_read, funct3) || misaligned(funct3, addr[1:0]);
`else
    assign off_in = align_off(funct3, addr[1:0]);
    assign bad    = !f3_legal(mem_read, funct3);
`endif

    assign accept = (state_q == DMA_IDLE) && req_valid && (mem_read || mem_write);
    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

    // Store lanes are replicated so the slave just honours bus_be.
    always_comb begin
        case (funct3[1:0])
            2'b00: begin
                be_in = 4'b0001 << off_in;
                wd_in = {4{wdata[7:0]}};
            end
            2'b01: begin
                be_in = off_in[1] ? 4'b1100 : 4'b0011;
                wd_in = {2{wdata[15:0]}};
            end
            default: begin
                be_in = 4'b1111;
                wd_in = wdata;
            end
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        is_rd_d     = is_rd_q;
        f3_d        = f3_q;
        off_d       = off_q;
        rdata_d     = rdata_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;
        case (state_q)
            DMA_IDLE: begin
                if (accept) begin
                    is_rd_d = mem_read;
                    f3_d    = funct3;
                    off_d   = off_in;
                    rdata_d = 32'h0;
                    cnt_d   = '0;
                    err_d   = bad;
                    if (bad) begin
                        state_d = DMA_RESP;
                    end else begin
                        state_d     = DMA_BUS;
                        bus_req_d   = 1'b1;
                        bus_we_d    = !mem_read;
                        bus_addr_d  = {addr[31:2], 2'b00};
                        bus_be_d    = be_in;
                        bus_wdata_d = mem_read ? 32'h0 : wd_in;
                    end
                end
            end
            DMA_BUS: begin
                if (bus_ack) begin
                    rdata_d = bus_rdata;
                    state_d = DMA_RESP;
                end else if ((TIMEOUT != 0) && (cnt_inc == CW'(TIMEOUT))) begin
                    err_d   = 1'b1;
                    state_d = DMA_RESP;
                end else begin
                    cnt_d = cnt_inc;
                end
                if (state_d == DMA_RESP) begin
                    bus_req_d   = 1'b0;
                    bus_we_d    = 1'b0;
                    bus_be_d    = 4'h0;
                    bus_wdata_d = 32'h0;
                end
            end
            DMA_RESP: state_d = DMA_IDLE;
            default:  state_d = DMA_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= DMA_IDLE;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            is_rd_q     <= 1'b0;
            f3_q        <= 3'h0;
            off_q       <= 2'h0;
            rdata_q     <= 32'h0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'h0;
            bus_be_q    <= 4'h0;
            bus_wdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            is_rd_q     <= is_rd_d;
            f3_q        <= f3_d;
            off_q       <= off_d;
            rdata_q     <= rdata_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
        end
    end

    data_mem_access_unit_load_extend u_ext (
        .word   (rdata_q),
        .off    (off_q),
        .funct3 (f3_q),
        .result (ext)
    );

    assign stall     = accept || (state_q == DMA_BUS);
    assign rsp_valid = (state_q == DMA_RESP);
    assign rsp_err   = rsp_valid && err_q;
    assign rsp_rdata = (rsp_valid && !err_q && is_rd_q) ? ext : 32'h0;
    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_be    = bus_be_q;
    assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_data_mem_access_unit.sv
// Scoreboard bench for data_mem_access_unit: loads, stores, timeout, bad funct3, reset.
// Misaligned expectations follow MISALIGN_TRAP_EN like the design.
import data_mem_access_unit_pkg::*;

module tb_data_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, mem_read, mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic        stall, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        bus_req, bus_we, bus_ack;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    data_mem_access_unit #(.TIMEOUT(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .funct3    (funct3),
        .addr      (addr),
        .wdata     (wdata),
        .stall     (stall),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_be    (bus_be),
        .bus_wdata (bus_wdata),
        .bus_ack   (bus_ack),
        .bus_rdata (bus_rdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_rsp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rsp_rdata", rsp_rdata, e.rdata);
                check("rsp_err", {31'h0, rsp_err}, {31'h0, e.err});
            end
        end
    end

    task automatic run(
        input string       tag,
        input logic        rd,
        input logic        wr,
        input logic [2:0]  f3,
        input logic [31:0] a,
        input logic [31:0] wd,
        input int          ack_at,
        input logic [31:0] rword,
        input logic [31:0] x_rdata,
        input logic        x_err,
        input int          x_bus,
        input logic [31:0] x_addr,
        input logic        x_we,
        input logic [3:0]  x_be,
        input logic [31:0] x_wdata
    );
        int  stall_n;
        int  req_n;
        bit  done;
        sb.push_back('{rdata: x_rdata, err: x_err});
        @(negedge clk);
        req_valid = 1'b1;
        mem_read  = rd;
        mem_write = wr;
        funct3    = f3;
        addr      = a;
        wdata     = wd;
        #1;
        stall_n = stall ? 1 : 0;
        req_n   = 0;
        done    = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            req_valid = 1'b0;
            mem_read  = 1'b0;
            mem_write = 1'b0;
            bus_ack   = (i == ack_at);
            bus_rdata = (i == ack_at) ? rword : 32'h0;
            #1;
            if (rsp_valid) begin
                done = 1'b1;
                break;
            end
            stall_n += stall ? 1 : 0;
            if (bus_req) begin
                req_n++;
                if (req_n == 1) begin
                    check({tag, "_addr"}, bus_addr, x_addr);
                    check({tag, "_we"}, {31'h0, bus_we}, {31'h0, x_we});
                    if (x_we) begin
                        check({tag, "_be"}, {28'h0, bus_be}, {28'h0, x_be});
                        check({tag, "_wdata"}, bus_wdata, x_wdata);
                    end
                end
            end
        end
        bus_ack   = 1'b0;
        bus_rdata = 32'h0;
        check({tag, "_done"}, {31'h0, done}, 32'd1);
        check({tag, "_stall_rsp"}, {31'h0, stall}, 32'd0);
        check({tag, "_stall_cycles"}, stall_n, 1 + x_bus);
        check({tag, "_req_cycles"}, req_n, x_bus);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        funct3    = 3'h0;
        addr      = 32'h0;
        wdata     = 32'h0;
        bus_ack   = 1'b0;
        bus_rdata = 32'h0;
        #1;
        check("rst_stall", {31'h0, stall}, 32'd0);
        check("rst_rsp_valid", {31'h0, rsp_valid}, 32'd0);
        check("rst_rsp_err", {31'h0, rsp_err}, 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_bus_req", {31'h0, bus_req}, 32'd0);
        check("rst_bus_we", {31'h0, bus_we}, 32'd0);
        check("rst_bus_addr", bus_addr, 32'h0);
        check("rst_bus_be", {28'h0, bus_be}, 32'h0);
        check("rst_bus_wdata", bus_wdata, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run("sw", 0, 1, F3_SW, 32'h104, 32'hDEADBEEF, 2, 32'h0,
            32'h0, 0, 2, 32'h104, 1, 4'hF, 32'hDEADBEEF);
        run("lb", 1, 0, F3_LB, 32'h103, 32'h0, 1, 32'h80FF_0000,
            32'hFFFFFF80, 0, 1, 32'h100, 0, 4'h0, 32'h0);
        run("lbu", 1, 0, F3_LBU, 32'h103, 32'h0, 1, 32'h80FF_0000,
            32'h00000080, 0, 1, 32'h100, 0, 4'h0, 32'h0);
        run("lhu", 1, 0, F3_LHU, 32'h102, 32'h0, 1, 32'h80FF_0000,
            32'h000080FF, 0, 1, 32'h100, 0, 4'h0, 32'h0);
        run("lh", 1, 0, F3_LH, 32'h100, 32'h0, 1, 32'h0000_8001,
            32'hFFFF8001, 0, 1, 32'h100, 0, 4'h0, 32'h0);
        run("lw", 1, 0, F3_LW, 32'h108, 32'h0, 3, 32'h12345678,
            32'h12345678, 0, 3, 32'h108, 0, 4'h0, 32'h0);
        run("sb", 0, 1, F3_SB, 32'h201, 32'h0000_00AB, 1, 32'h0,
            32'h0, 0, 1, 32'h200, 1, 4'b0010, 32'hABABABAB);
        run("sh_hi", 0, 1, F3_SH, 32'h202, 32'h1234_BEEF, 1, 32'h0,
            32'h0, 0, 1, 32'h200, 1, 4'b1100, 32'hBEEFBEEF);
        run("sh_lo", 0, 1, F3_SH, 32'h200, 32'h0000_CAFE, 1, 32'h0,
            32'h0, 0, 1, 32'h200, 1, 4'b0011, 32'hCAFECAFE);
        run("rdwr", 1, 1, F3_LW, 32'h10C, 32'h5555_5555, 1, 32'h0BADF00D,
            32'h0BADF00D, 0, 1, 32'h10C, 0, 4'h0, 32'h0);
        run("tmo", 1, 0, F3_LW, 32'h110, 32'h0, 0, 32'h0,
            32'h0, 1, 16, 32'h110, 0, 4'h0, 32'h0);
        run("bad_ld", 1, 0, 3'b011, 32'h114, 32'h0, 0, 32'h0,
            32'h0, 1, 0, 32'h0, 0, 4'h0, 32'h0);
        run("bad_st", 0, 1, 3'b100, 32'h118, 32'h0, 0, 32'h0,
            32'h0, 1, 0, 32'h0, 0, 4'h0, 32'h0);
`ifdef MISALIGN_TRAP_EN
        run("lw_mis", 1, 0, F3_LW, 32'h106, 32'h0, 0, 32'h0,
            32'h0, 1, 0, 32'h0, 0, 4'h0, 32'h0);
        run("lh_mis", 1, 0, F3_LH, 32'h103, 32'h0, 0, 32'h0,
            32'h0, 1, 0, 32'h0, 0, 4'h0, 32'h0);
        run("sw_mis", 0, 1, F3_SW, 32'h107, 32'h11223344, 0, 32'h0,
            32'h0, 1, 0, 32'h0, 0, 4'h0, 32'h0);
`else
        run("lw_mis", 1, 0, F3_LW, 32'h106, 32'h0, 1, 32'h55AA55AA,
            32'h55AA55AA, 0, 1, 32'h104, 0, 4'h0, 32'h0);
        run("lh_mis", 1, 0, F3_LH, 32'h103, 32'h0, 1, 32'h8001_7FFF,
            32'hFFFF8001, 0, 1, 32'h100, 0, 4'h0, 32'h0);
        run("sw_mis", 0, 1, F3_SW, 32'h107, 32'h11223344, 1, 32'h0,
            32'h0, 0, 1, 32'h104, 1, 4'hF, 32'h11223344);
`endif

        @(negedge clk);
        req_valid = 1'b1;
        mem_read  = 1'b1;
        funct3    = F3_LW;
        addr      = 32'h300;
        @(negedge clk);
        req_valid = 1'b0;
        mem_read  = 1'b0;
        #1;
        check("mid_bus_req", {31'h0, bus_req}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_bus_req", {31'h0, bus_req}, 32'd0);
        check("async_stall", {31'h0, stall}, 32'd0);
        check("async_rsp_valid", {31'h0, rsp_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus_ack   = 1'b1;
        bus_rdata = 32'hFFFF_FFFF;
        #1;
        check("stale_ack_stall", {31'h0, stall}, 32'd0);
        @(negedge clk);
        bus_ack   = 1'b0;
        bus_rdata = 32'h0;
        #1;
        check("stale_ack_rsp", {31'h0, rsp_valid}, 32'd0);
        check("stale_ack_req", {31'h0, bus_req}, 32'd0);

        run("lw_fresh", 1, 0, F3_LW, 32'h300, 32'h0, 2, 32'hCAFEF00D,
            32'hCAFEF00D, 0, 2, 32'h300, 0, 4'h0, 32'h0);

        repeat (2) @(negedge clk);
        check("sb_drain", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
